// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: pattern constants (bit 0 = top ... bit 6 = middle),
// the forward encode table and the reader FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  // B and D alias 8 and 0 on this display; the reverse lookup can never return them.
  localparam logic [6:0] SEG_B     = 7'b1111111;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    StSettle,
    StLocked
  } seg7_state_e;

  function automatic logic [6:0] seg7_encode(input logic [3:0] value);
    logic [6:0] pat;
    case (value)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_lookup.sv
// Combinational reverse lookup: segment pattern to hex value, with hit and blank flags.
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       hit,
  output logic       is_blank
);

  always_comb begin
    value = 4'h0;
    hit   = 1'b1;
    case (pattern)
      SEG_0:   value = 4'h0;
      SEG_1:   value = 4'h1;
      SEG_2:   value = 4'h2;
      SEG_3:   value = 4'h3;
      SEG_4:   value = 4'h4;
      SEG_5:   value = 4'h5;
      SEG_6:   value = 4'h6;
      SEG_7:   value = 4'h7;
      SEG_8:   value = 4'h8;
      SEG_9:   value = 4'h9;
      SEG_A:   value = 4'hA;
      SEG_C:   value = 4'hC;
      SEG_E:   value = 4'hE;
      SEG_F:   value = 4'hF;
      default: hit   = 1'b0;
    endcase
  end

  assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_reader.sv
// Synchronises a 7-segment bus, waits for STABLE_CYCLES equal samples, then decodes once.
// Optional SEG7_READER_BLANK_EN accepts the all-off pattern as a blank display.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] segments_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       pattern_err,
`ifdef SEG7_READER_BLANK_EN
  output logic       blank,
`endif
  output logic       locked
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

`ifdef SEG7_READER_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  logic [6:0]      s1_q, s2_q;
  logic [6:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  seg7_state_e     state_q, state_d;
  logic [3:0]      digit_q, digit_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            decide;

  logic [3:0]      lk_value;
  logic            lk_hit;
  logic            lk_blank;

  seg7_lookup u_lookup (
    .pattern  (cand_q),
    .value    (lk_value),
    .hit      (lk_hit),
    .is_blank (lk_blank)
  );

  // Two-flop synchroniser; runs even while decoding is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= segments_in;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    decide  = 1'b0;

    if (!enable) begin
      state_d = StSettle;
      cnt_d   = '0;
      cand_d  = s2_q;
    end else if (s2_q != cand_q) begin
      state_d = StSettle;
      cnt_d   = '0;
      cand_d  = s2_q;
    end else if (state_q == StSettle) begin
      if (cnt_q < CntLast) begin
        cnt_d = cnt_q + CntW'(1);
      end else begin
        state_d = StLocked;
        decide  = 1'b1;
        if (lk_hit) begin
          digit_d = lk_value;
          valid_d = 1'b1;
        end else if (!(BlankEn && lk_blank)) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StSettle;
      cand_q  <= '0;
      cnt_q   <= '0;
      digit_q <= 4'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

`ifdef SEG7_READER_BLANK_EN
  logic blank_q;

  // Any decision other than a blank one clears the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q <= 1'b0;
    end else if (!enable) begin
      blank_q <= 1'b0;
    end else if (decide) begin
      blank_q <= lk_blank;
    end
  end

  assign blank = blank_q;
`else
  logic unused_decide;
  assign unused_decide = decide;
`endif

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign pattern_err = err_q;
  assign locked      = (state_q == StLocked);

endmodule

// File: tb/tb_seg7_reader.sv
// Randomised and directed bench for seg7_reader against a run-length reference model.
module tb_seg7_reader;

  localparam int N = 4;
`ifdef SEG7_READER_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [6:0] segments_in;
  logic [3:0] digit;
  logic       digit_valid;
  logic       pattern_err;
  logic       locked;
`ifdef SEG7_READER_BLANK_EN
  logic       blank;
`endif

  seg7_reader #(.STABLE_CYCLES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .segments_in (segments_in),
    .digit       (digit),
    .digit_valid (digit_valid),
    .pattern_err (pattern_err),
`ifdef SEG7_READER_BLANK_EN
    .blank       (blank),
`endif
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: input delay line, stable run length, decision outputs.
  logic [6:0] m_s1, m_s2, m_last;
  int         m_run;
  bit         m_lk, m_dv, m_pe, m_blank;
  logic [3:0] m_digit;

  // Observation counters for directed checks.
  int n_dv, n_pe, step_no, first_dv;
  bit saw_unlock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Forward display table; the reverse search returns the lowest matching value.
  function automatic logic [6:0] fwd(input int v);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07,
          7'h7F, 7'h67, 7'h77, 7'h7F, 7'h39, 7'h3F, 7'h79, 7'h71};
    return t[v];
  endfunction

  function automatic int decode(input logic [6:0] p);
    for (int v = 0; v < 16; v++) begin
      if (fwd(v) == p) return v;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_last = '0; m_run = 0;
    m_lk = 0; m_dv = 0; m_pe = 0; m_blank = 0; m_digit = 4'h0;
  endtask

  // One clock edge: a decision fires when a value has been seen N edges in a row
  // (with enable) after the edge that first captured it.
  task automatic model_edge(input logic en, input logic [6:0] seg);
    logic [6:0] v;
    int d;
    v = m_s2;
    m_dv = 0;
    m_pe = 0;
    if (!en) begin
      m_run = 0; m_lk = 0; m_blank = 0;
    end else if (v != m_last) begin
      m_run = 0; m_lk = 0;
    end else if (!m_lk) begin
      m_run++;
      if (m_run == N) begin
        m_lk = 1;
        d = decode(v);
        if (d >= 0) begin
          m_digit = 4'(d); m_dv = 1; m_blank = 0;
        end else if (BLANK_EN && v == 7'h00) begin
          m_blank = 1;
        end else begin
          m_pe = 1; m_blank = 0;
        end
      end
    end
    m_last = v;
    m_s2 = m_s1;
    m_s1 = seg;
  endtask

  task automatic compare_all();
    check("digit", 32'(digit), 32'(m_digit));
    check("digit_valid", 32'(digit_valid), 32'(m_dv));
    check("pattern_err", 32'(pattern_err), 32'(m_pe));
    check("locked", 32'(locked), 32'(m_lk));
`ifdef SEG7_READER_BLANK_EN
    check("blank", 32'(blank), 32'(m_blank));
`endif
    if (digit_valid && pattern_err) check("exclusive_pulses", 32'(1), 32'(0));
  endtask

  // Called at a negedge: drive inputs, let the posedge happen, check at the next negedge.
  task automatic step(input logic en, input logic [6:0] seg);
    step_no++;
    enable = en;
    segments_in = seg;
    model_edge(en, seg);
    @(negedge clk);
    compare_all();
    if (digit_valid) begin
      n_dv++;
      if (first_dv == 0) first_dv = step_no;
    end
    if (pattern_err) n_pe++;
    if (!locked) saw_unlock = 1;
  endtask

  task automatic clear_obs();
    n_dv = 0; n_pe = 0; step_no = 0; first_dv = 0; saw_unlock = 0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_digit", 32'(digit), 32'(0));
    check("rst_valid", 32'(digit_valid), 32'(0));
    check("rst_err", 32'(pattern_err), 32'(0));
    check("rst_locked", 32'(locked), 32'(0));
`ifdef SEG7_READER_BLANK_EN
    check("rst_blank", 32'(blank), 32'(0));
`endif
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] pat;
    int len;
    int pick;
    enable = 1'b1;
    segments_in = 7'b1011011;
    do_reset(2);

    // Constant input at reset release decodes once.
    clear_obs();
    repeat (12) step(1'b1, 7'b1011011);
    check("t1_pulses", 32'(n_dv), 32'(1));
    check("t1_digit", 32'(digit), 32'(2));
    check("t1_locked", 32'(locked), 32'(1));

    // Changed pattern: pulse on the 7th edge after it is applied.
    clear_obs();
    repeat (12) step(1'b1, 7'b1111111);
    check("t2_pulses", 32'(n_dv), 32'(1));
    check("t2_latency", 32'(first_dv), 32'(7));
    check("t2_digit", 32'(digit), 32'(8));

    // Unknown pattern flags an error and keeps the digit.
    clear_obs();
    repeat (12) step(1'b1, 7'b0000001);
    check("t3_err", 32'(n_pe), 32'(1));
    check("t3_digit", 32'(digit), 32'(8));
    check("t3_locked", 32'(locked), 32'(1));

    // Short glitch between steady periods.
    repeat (12) step(1'b1, 7'b0000110);
    clear_obs();
    repeat (2) step(1'b1, 7'b1111100);
    repeat (12) step(1'b1, 7'b0000110);
    check("t4_pulses", 32'(n_dv), 32'(1));
    check("t4_err", 32'(n_pe), 32'(0));
    check("t4_unlock", 32'(saw_unlock), 32'(1));
    check("t4_digit", 32'(digit), 32'(1));

    // Reset mid-settle abandons the candidate; decode after release.
    repeat (3) step(1'b1, 7'b1100111);
    do_reset(2);
    clear_obs();
    repeat (12) step(1'b1, 7'b1100111);
    check("t5_pulses", 32'(n_dv), 32'(1));
    check("t5_digit", 32'(digit), 32'(9));

    // All-off pattern.
    clear_obs();
    repeat (12) step(1'b1, 7'b0000000);
    check("t6_valid", 32'(n_dv), 32'(0));
    check("t6_err", 32'(n_pe), 32'(BLANK_EN ? 0 : 1));
`ifdef SEG7_READER_BLANK_EN
    check("t6_blank", 32'(blank), 32'(1));
`endif

    // Dropping enable on the decision edge suppresses the decision.
    clear_obs();
    repeat (6) step(1'b1, 7'b1011011);
    step(1'b0, 7'b1011011);
    check("t7_suppressed", 32'(n_dv), 32'(0));
    repeat (8) step(1'b1, 7'b1011011);
    check("t7_pulses", 32'(n_dv), 32'(1));
    check("t7_digit", 32'(digit), 32'(2));

    // Randomised runs of held patterns with enable drops and occasional resets.
    for (int r = 0; r < 300; r++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 6) pat = fwd(int'($urandom_range(0, 15)));
      else if (pick < 9) pat = 7'($urandom);
      else pat = 7'h00;
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) begin
        step(($urandom_range(0, 11) != 0), pat);
      end
      if ($urandom_range(0, 40) == 0) do_reset(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
